// File: rtl/cblock_cfg_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cblock_cfg_loader_if
//  Description : Handshake and write-bus bundle between the configuration
//                port, the Cblock column loader and the Cblock write inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cblock_cfg_loader_if #(
    parameter int NUM_CBLOCKS = 4,
    parameter int CFG_WIDTH   = 18,
    parameter int IDX_W       = (NUM_CBLOCKS > 1) ? $clog2(NUM_CBLOCKS) : 1
);
    logic                   start_i;
    logic                   cfg_data_i;
    logic                   cfg_v_i;
    logic                   cfg_ready_o;
    logic [NUM_CBLOCKS-1:0] wr_en_o;
    logic [CFG_WIDTH-1:0]   bits_o;
    logic [IDX_W-1:0]       blk_idx_o;
    logic                   busy_o;
    logic                   done_o;

    // Loader side: consumes the serial stream, drives the Cblock writes.
    modport slave (
        input  start_i, cfg_data_i, cfg_v_i,
        output cfg_ready_o, wr_en_o, bits_o, blk_idx_o, busy_o, done_o
    );

    // Configuration-port side: offers the stream, observes progress.
    modport master (
        output start_i, cfg_data_i, cfg_v_i,
        input  cfg_ready_o, wr_en_o, bits_o, blk_idx_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/cblock_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cblock_cfg_loader
//  Description : Assembles a serial MSB-first bitstream into one CFG_WIDTH-bit
//                word per Cblock and writes the column with one-hot strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cblock_cfg_loader #(
    parameter int NUM_CBLOCKS = 4,
    parameter int CFG_WIDTH   = 18,
    parameter int IDX_W       = (NUM_CBLOCKS > 1) ? $clog2(NUM_CBLOCKS) : 1
) (
    input wire                  clk_i,
    input wire                  reset_i,
    cblock_cfg_loader_if.slave  bus
);

    localparam int CNT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(CFG_WIDTH - 1);
    localparam logic [IDX_W-1:0] c_last_blk = IDX_W'(NUM_CBLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [IDX_W-1:0]       blk_idx_q;
    logic [CFG_WIDTH-1:0]   shift_q;
    logic [CFG_WIDTH-1:0]   bits_q;
    logic [NUM_CBLOCKS-1:0] wr_en_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;

    logic [CFG_WIDTH-1:0]   shift_d;
    logic [NUM_CBLOCKS-1:0] onehot_d;

    // Shift register with the incoming bit appended at the LSB; the
    // whole-word shift also covers the degenerate CFG_WIDTH == 1 case.
    assign shift_d = (shift_q << 1) | CFG_WIDTH'(bus.cfg_data_i);

    // Decode the current block index into its write strobe.
    always_comb begin
        onehot_d = '0;
        for (int k = 0; k < NUM_CBLOCKS; k++) begin
            if (blk_idx_q == IDX_W'(k)) begin
                onehot_d[k] = 1'b1;
            end
        end
    end

    // Pass sequencer: all outputs are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            blk_idx_q <= '0;
            shift_q   <= '0;
            bits_q    <= '0;
            wr_en_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    blk_idx_q <= '0;
                    if (bus.start_i) begin
                        state_q <= SHIFT;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.cfg_v_i && ready_q) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == c_last_bit) begin
                            // Word complete: publish it and strobe this block.
                            bit_cnt_q <= '0;
                            bits_q    <= shift_d;
                            wr_en_q   <= onehot_d;
                            ready_q   <= 1'b0;
                            state_q   <= WRITE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    wr_en_q <= '0;
                    if (blk_idx_q == c_last_blk) begin
                        blk_idx_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        blk_idx_q <= blk_idx_q + IDX_W'(1);
                        ready_q   <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready_o = ready_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.bits_o      = bits_q;
    assign bus.blk_idx_o   = blk_idx_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;

endmodule
`default_nettype wire
